// File: rtl/param_digital_clock.sv
// Parametrised hh:mm:ss BCD clock with 1 Hz prescaler, button time-set, 12/24 h view and hour chime.
// Define DIGITAL_CLOCK_ALARM_EN to add the alarm_hour/alarm_min/alarm_on inputs and the alarm output.
module param_digital_clock #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int CHIME_SECS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] set_mode,
  input  logic       inc,
  input  logic       mode12,
  output logic [7:0] hour,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       pm,
  output logic       sec_tick,
  output logic       tweet
`ifdef DIGITAL_CLOCK_ALARM_EN
  ,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_min,
  input  logic       alarm_on,
  output logic       alarm
`endif
);

  localparam int             PW         = $clog2(CLK_FREQ);
  localparam logic [PW-1:0]  PRESC_MAX  = PW'(CLK_FREQ - 1);
  localparam logic [5:0]     CHIME_LOAD = 6'(CHIME_SECS);

  logic [PW-1:0] presc;
  logic [7:0]    hour24;
  logic [5:0]    chime_cnt;
  logic          run;
  logic          tick;
  logic          adjust;
  logic          top_of_hour;
  logic [7:0]    sec_next;
  logic [7:0]    min_next;
  logic [7:0]    hour_next;
  logic          sec_wrap;
  logic          min_wrap;

  // Returns {wrap, value}: BCD 00..59 increment.
  function automatic logic [8:0] bcd60_inc(input logic [7:0] v);
    if (v == 8'h59) return 9'h100;
    if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] hour_inc(input logic [7:0] v);
    if (v == 8'h23) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Returns {pm, bcd_hour} for the 12 h view of a 24 h BCD hour.
  function automatic logic [8:0] disp12(input logic [7:0] h);
    if (h == 8'h00) return {1'b0, 8'h12};
    if (h < 8'h12)  return {1'b0, h};
    if (h == 8'h12) return {1'b1, 8'h12};
    if (h < 8'h20)  return {1'b1, h - 8'h12};
    case (h)
      8'h20:   return {1'b1, 8'h08};
      8'h21:   return {1'b1, 8'h09};
      8'h22:   return {1'b1, 8'h10};
      default: return {1'b1, 8'h11};
    endcase
  endfunction

  assign run         = en && (set_mode == 2'b00);
  assign tick        = run && (presc == PRESC_MAX);
  assign adjust      = (set_mode != 2'b00);
  assign top_of_hour = tick && sec_wrap && (min_next == 8'h00);

  always_comb begin
    sec_next  = sec;
    min_next  = min;
    hour_next = hour24;
    sec_wrap  = 1'b0;
    min_wrap  = 1'b0;
    if (tick) begin
      {sec_wrap, sec_next} = bcd60_inc(sec);
      if (sec_wrap) {min_wrap, min_next} = bcd60_inc(min);
      if (min_wrap) hour_next = hour_inc(hour24);
    end else if (adjust && inc) begin
      // Set-mode adjustments never carry into the neighbouring field.
      case (set_mode)
        2'b01:   hour_next = hour_inc(hour24);
        2'b10:   {min_wrap, min_next} = bcd60_inc(min);
        default: sec_next = 8'h00;
      endcase
    end
  end

  // Prescaler and time registers; time advances on the edge that raises sec_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      sec_tick <= 1'b0;
      hour24   <= 8'h00;
      min      <= 8'h00;
      sec      <= 8'h00;
    end else begin
      sec_tick <= tick;
      if (!run || tick) presc <= '0;
      else              presc <= presc + PW'(1);
      hour24 <= hour_next;
      min    <= min_next;
      sec    <= sec_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tweet     <= 1'b0;
      chime_cnt <= 6'd0;
    end else if (adjust) begin
      tweet     <= 1'b0;
      chime_cnt <= 6'd0;
    end else if (tick) begin
      if (top_of_hour) begin
        tweet     <= 1'b1;
        chime_cnt <= CHIME_LOAD;
      end else if (chime_cnt != 6'd0) begin
        chime_cnt <= chime_cnt - 6'd1;
        if (chime_cnt == 6'd1) tweet <= 1'b0;
      end
    end
  end

  always_comb begin
    hour = hour24;
    pm   = 1'b0;
    if (mode12) {pm, hour} = disp12(hour24);
  end

`ifdef DIGITAL_CLOCK_ALARM_EN
  logic [5:0] alarm_ticks;
  logic       alarm_hit;

  assign alarm_hit = tick && alarm_on && (hour_next == alarm_hour) &&
                     (min_next == alarm_min) && (sec_next == 8'h00);

  // Alarm self-clears on the 60th tick after it fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm       <= 1'b0;
      alarm_ticks <= 6'd0;
    end else if (adjust || !alarm_on) begin
      alarm       <= 1'b0;
      alarm_ticks <= 6'd0;
    end else if (alarm_hit) begin
      alarm       <= 1'b1;
      alarm_ticks <= 6'd0;
    end else if (tick && alarm) begin
      alarm_ticks <= alarm_ticks + 6'd1;
      if (alarm_ticks == 6'd59) alarm <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_param_digital_clock.sv
// Directed bench for param_digital_clock (CLK_FREQ=10, CHIME_SECS=3) with an expected-value queue.
// Alarm steps are built only when DIGITAL_CLOCK_ALARM_EN is defined.
module tb_param_digital_clock;
  localparam int CF = 10;
  localparam int CS = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] set_mode;
  logic       inc;
  logic       mode12;
  logic [7:0] hour;
  logic [7:0] min;
  logic [7:0] sec;
  logic       pm;
  logic       sec_tick;
  logic       tweet;
`ifdef DIGITAL_CLOCK_ALARM_EN
  logic [7:0] alarm_hour;
  logic [7:0] alarm_min;
  logic       alarm_on;
  logic       alarm;
`endif

  int checks     = 0;
  int failures   = 0;
  int tick_total = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  param_digital_clock #(.CLK_FREQ(CF), .CHIME_SECS(CS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .set_mode(set_mode), .inc(inc), .mode12(mode12),
    .hour(hour), .min(min), .sec(sec), .pm(pm), .sec_tick(sec_tick), .tweet(tweet)
`ifdef DIGITAL_CLOCK_ALARM_EN
    , .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_on(alarm_on), .alarm(alarm)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (sec_tick === 1'b1) tick_total++;
  end

  task automatic expect_v(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_v(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL unexpected_output observed=%0h expected=none", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_inc(input int n);
    repeat (n) begin
      inc = 1'b1;
      @(negedge clk);
      inc = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_ticks(input int n);
    int cnt = 0;
    int cyc = 0;
    while (cnt < n && cyc < n * CF + 2 * CF) begin
      @(negedge clk);
      cyc++;
      if (sec_tick === 1'b1) cnt++;
    end
    expect_v("ticks_arrived", n);
    check_v(cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    int left;
    rst_n = 1'b0; en = 1'b0; set_mode = 2'b00; inc = 1'b0; mode12 = 1'b0;
`ifdef DIGITAL_CLOCK_ALARM_EN
    alarm_hour = 8'h07; alarm_min = 8'h30; alarm_on = 1'b0;
`endif
    cycles(3);
    expect_v("rst_hour", 8'h00);  check_v(hour);
    expect_v("rst_min", 8'h00);   check_v(min);
    expect_v("rst_sec", 8'h00);   check_v(sec);
    expect_v("rst_pm", 0);        check_v(pm);
    expect_v("rst_tick", 0);      check_v(sec_tick);
    expect_v("rst_tweet", 0);     check_v(tweet);
    mode12 = 1'b1; #1;
    expect_v("rst_hour12", 8'h12); check_v(hour);
    expect_v("rst_pm12", 0);       check_v(pm);
    mode12 = 1'b0;
    @(negedge clk);

    // free run: ticks at cycles 10, 20, 30
    rst_n = 1'b1; en = 1'b1;
    expect_v("tick_at", 10); expect_v("tick_at", 20); expect_v("tick_at", 30);
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (sec_tick === 1'b1) check_v(c);
    end
    left = exp_q.size();
    expect_v("missing_ticks", 0); check_v(left);
    expect_v("run_sec", 8'h03);  check_v(sec);
    expect_v("run_min", 8'h00);  check_v(min);
    expect_v("run_hour", 8'h00); check_v(hour);

    // set 23:58:00
    t0 = tick_total;
    set_mode = 2'b01; @(negedge clk); pulse_inc(23);
    expect_v("set_hour23", 8'h23); check_v(hour);
    expect_v("set_hold_sec", 8'h03); check_v(sec);
    expect_v("set_hold_min", 8'h00); check_v(min);
    set_mode = 2'b10; @(negedge clk); pulse_inc(58);
    set_mode = 2'b11; @(negedge clk); pulse_inc(1);
    expect_v("set_sec_clear", 8'h00); check_v(sec);
    expect_v("set_min58", 8'h58);     check_v(min);
    expect_v("set_keep_hour", 8'h23); check_v(hour);
    expect_v("no_tick_in_set", 0);    check_v(tick_total - t0);

    set_mode = 2'b00; wait_ticks(58);
    expect_v("t_sec58", 8'h58);  check_v(sec);
    expect_v("t_min58", 8'h58);  check_v(min);
    expect_v("t_tweet0", 0);     check_v(tweet);
    set_mode = 2'b10; @(negedge clk); pulse_inc(1);
    expect_v("pre_min59", 8'h59); check_v(min);
    expect_v("pre_sec58", 8'h58); check_v(sec);
    expect_v("pre_hour23", 8'h23); check_v(hour);

    // midnight rollover and chime length
    set_mode = 2'b00; wait_ticks(1);
    expect_v("sec59", 8'h59); check_v(sec);
    wait_ticks(1);
    expect_v("mid_hour", 8'h00); check_v(hour);
    expect_v("mid_min", 8'h00);  check_v(min);
    expect_v("mid_sec", 8'h00);  check_v(sec);
    expect_v("mid_tweet", 1);    check_v(tweet);
    n = 0;
    while (tweet === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    expect_v("tweet_cycles", CS * CF); check_v(n);

    // enable freeze mid-second
    cycles(4);
    t0 = tick_total;
    en = 1'b0; cycles(25);
    expect_v("en0_ticks", 0);   check_v(tick_total - t0);
    expect_v("en0_sec", 8'h03); check_v(sec);
    en = 1'b1;
    n = 0;
    while (sec_tick !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    expect_v("en_restart", CF); check_v(n);
    expect_v("en_sec", 8'h04);  check_v(sec);

    // 12 h display
    mode12 = 1'b1; #1;
    expect_v("h12_00", 8'h12); check_v(hour);
    expect_v("pm_00", 0);      check_v(pm);
    set_mode = 2'b01; @(negedge clk); pulse_inc(12);
    expect_v("h12_12", 8'h12); check_v(hour);
    expect_v("pm_12", 1);      check_v(pm);
    pulse_inc(3);
    expect_v("h12_15", 8'h03); check_v(hour);
    expect_v("pm_15", 1);      check_v(pm);
    mode12 = 1'b0; #1;
    expect_v("h24_15", 8'h15); check_v(hour);
    expect_v("pm24_15", 0);    check_v(pm);
    mode12 = 1'b1;
    pulse_inc(8);
    expect_v("h12_23", 8'h11); check_v(hour);
    expect_v("pm_23", 1);      check_v(pm);
    mode12 = 1'b0;

    // hour wrap in set mode
    t0 = tick_total;
    pulse_inc(1);
    expect_v("wrap_hour", 8'h00); check_v(hour);
    expect_v("wrap_min", 8'h00);  check_v(min);
    expect_v("wrap_sec", 8'h04);  check_v(sec);
    expect_v("wrap_tweet", 0);    check_v(tweet);
    expect_v("wrap_ticks", 0);    check_v(tick_total - t0);

    // chime cleared by entering set mode
    set_mode = 2'b10; @(negedge clk); pulse_inc(59);
    set_mode = 2'b11; @(negedge clk); pulse_inc(1);
    set_mode = 2'b00; wait_ticks(60);
    expect_v("h1_hour", 8'h01); check_v(hour);
    expect_v("h1_tweet", 1);    check_v(tweet);
    cycles(3);
    set_mode = 2'b01; @(negedge clk);
    expect_v("set_clears_tweet", 0); check_v(tweet);

    // chime aborted by async reset
    set_mode = 2'b10; @(negedge clk); pulse_inc(59);
    set_mode = 2'b11; @(negedge clk); pulse_inc(1);
    set_mode = 2'b00; wait_ticks(60);
    expect_v("h2_hour", 8'h02); check_v(hour);
    expect_v("h2_tweet", 1);    check_v(tweet);
    cycles(5);
    #2 rst_n = 1'b0;
    #1;
    expect_v("arst_tweet", 0);    check_v(tweet);
    expect_v("arst_hour", 8'h00); check_v(hour);
    expect_v("arst_min", 8'h00);  check_v(min);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DIGITAL_CLOCK_ALARM_EN
    alarm_on = 1'b1;
    set_mode = 2'b01; @(negedge clk); pulse_inc(7);
    set_mode = 2'b10; @(negedge clk); pulse_inc(29);
    set_mode = 2'b00; wait_ticks(59);
    expect_v("al_pre_sec", 8'h59);  check_v(sec);
    expect_v("al_pre_min", 8'h29);  check_v(min);
    expect_v("al_pre_hour", 8'h07); check_v(hour);
    expect_v("al_pre", 0);          check_v(alarm);
    wait_ticks(1);
    expect_v("al_min", 8'h30); check_v(min);
    expect_v("al_fire", 1);    check_v(alarm);
    alarm_on = 1'b0;
    @(negedge clk);
    expect_v("al_off", 0); check_v(alarm);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_digital_clock.md
Name: param_digital_clock

Overview:
- Parametrised successor to the team's fixed 24 h BCD clock core.
- Generates a 1 Hz tick from the system clock and keeps hh:mm:ss in packed BCD.
- Supports a button-driven time-set mode, 12/24 h display, a configurable-length top-of-hour chime and an optional alarm.
- Sits between board inputs and the 6-digit seven-segment display driver; its hour/min/sec buses feed the digit nibbles directly.

Parameters:
- CLK_FREQ, 50_000_000: system clock cycles per second; prescaler terminal count is CLK_FREQ-1; minimum 2.
- CHIME_SECS, 5: number of 1 Hz ticks `tweet` stays high after the hour rolls over; range 1..59.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; when 0 the prescaler and time are frozen.
- set_mode  in  2  00 run, 01 set hour, 10 set minute, 11 set second.
- inc  in  1  single-cycle synchronous pulse; adjusts the selected field.
- mode12  in  1  1 selects 12 h display, 0 selects 24 h.
- hour  out  8  BCD hour, [7:4] tens, [3:0] units.
- min  out  8  BCD minute.
- sec  out  8  BCD second.
- pm  out  1  PM flag, meaningful only when mode12=1.
- sec_tick  out  1  one-cycle pulse on each 1 Hz tick.
- tweet  out  1  top-of-hour chime level.

Behaviour:
- Reset (async, rst_n=0):
  - Internal time 00:00:00 and prescaler 0.
  - sec_tick=0, tweet=0, chime counter 0.
  - Outputs read hour=00 (or 12 if mode12=1), min=00, sec=00, pm=0.
- Prescaler:
  - Counts only when en=1 and set_mode=00; otherwise it holds at 0.
  - At CLK_FREQ-1 it wraps to 0 and sec_tick pulses high for that cycle.
  - The time update happens on the same edge that registers sec_tick.
  - After leaving set mode, or after en rises, the first tick comes CLK_FREQ cycles later.
- Time counting:
  - Counters are BCD, units 0-9 and tens 0-5.
  - sec 59→00 carries to min; min 59→00 carries to hour; hour 23→00.
  - Internal hour is always 24 h.
  - 23:59:59 plus one tick gives 00:00:00.
- Set mode (set_mode≠00):
  - No ticks; time is held except for inc.
  - set hour: inc adds 1 to the hour, wrapping 23→00 with no carry.
  - set minute: inc wraps 59→00 with no carry.
  - set second: inc clears sec to 00.
  - inc while set_mode=00 is ignored.
  - set_mode changes take effect on the next edge.
- Chime:
  - Triggers only on a tick that produces mm:ss=00:00.
  - On that edge, tweet=1 and the chime counter loads CHIME_SECS.
  - Each following tick decrements the counter; tweet drops on the tick that reaches 0.
  - tweet is therefore high for exactly CHIME_SECS×CLK_FREQ cycles.
  - Setting the time to xx:00:00 never triggers a chime.
  - Entering set mode clears tweet and the chime counter immediately on the next edge.
  - With en=0 the chime freezes along with the clock.
- 12 h display (combinational from internal hour and mode12):
  - Internal 00 → 12, pm=0.
  - 01-11 → unchanged, pm=0.
  - 12 → 12, pm=1.
  - 13-23 → 01-11, pm=1.
  - With mode12=0: pm=0 and hour equals the internal hour.
- Reset mid-operation aborts any chime, set or alarm activity immediately.

Optional Feature:
- Macro: DIGITAL_CLOCK_ALARM_EN.
- When defined, three inputs and one output are added:
  - alarm_hour (8-bit BCD, 24 h).
  - alarm_min (8-bit BCD).
  - alarm_on (1 bit).
  - alarm (output, reset 0).
- Alarm trigger: on a tick that produces alarm_hour:alarm_min:00 while alarm_on=1, alarm goes to 1.
- Alarm clears on whichever comes first:
  - alarm_on=0, on the next edge.
  - The 60th following tick.
  - Entering set mode.
- Tweet and alarm may both be active at once.
- When undefined, these ports and their logic are absent, and behaviour is otherwise identical.

Test Plan:
- CLK_FREQ=10: release reset, en=1, run 35 cycles → sec_tick at cycles 10, 20 and 30; sec=03; hour/min=00.
- Time set to 23:59:58 via set mode, then run 2 ticks → 00:00:00 and tweet=1.
- Same run with CHIME_SECS=3 → tweet low after exactly 30 cycles.
- set_mode=01 at hour 23 plus one inc → hour=00, min/sec unchanged, tweet=0, no sec_tick.
- set_mode=11 → sec=00.
- mode12=1 with internal hours 00, 12 and 15 → hour/pm = 12/0, 12/1, 03/1.
- en=0 for 25 cycles mid-second → no sec_tick; after en=1 the next tick comes 10 cycles later.
- Reset asserted during a chime → tweet=0 asynchronously.
- DIGITAL_CLOCK_ALARM_EN, alarm 07:30 with alarm_on=1, start at 07:29:59, one tick → alarm=1.
- Same setup, drop alarm_on → alarm=0 one cycle later.
